// File: rtl/mod_id_ex.sv
// rtl/mod_id_ex.sv - ID/EX stage register with MEM/WB forwarding, load-use bubbles and a bubble counter

module mod_id_ex #(
  parameter int DW  = 32,
  parameter int OPW = 4,
  parameter int CW  = 16
) (
  input  logic           iClk,
  input  logic           iReset_n,
  input  logic           iValid,
  input  logic [31:0]    iPC,
  input  logic [DW-1:0]  iRsData,
  input  logic [DW-1:0]  iRtData,
  input  logic [DW-1:0]  iImm,
  input  logic [4:0]     iShamt,
  input  logic [OPW-1:0] iALUOp,
  input  logic           iSrcBImm,
  input  logic [4:0]     iRsAddr,
  input  logic [4:0]     iRtAddr,
  input  logic           iUseRs,
  input  logic           iUseRt,
  input  logic [4:0]     iWriteAddr,
  input  logic           iRegWrite,
  input  logic           iMemRead,
  input  logic           iMemWrite,
  input  logic           iStall,
  input  logic           iFlush,
  input  logic           iFwdMemWe,
  input  logic [4:0]     iFwdMemAddr,
  input  logic [DW-1:0]  iFwdMemData,
  input  logic           iFwdWbWe,
  input  logic [4:0]     iFwdWbAddr,
  input  logic [DW-1:0]  iFwdWbData,
  output logic [DW-1:0]  oNumber1,
  output logic [DW-1:0]  oNumber2,
  output logic [4:0]     oShamt,
  output logic [OPW-1:0] oALUOp,
  output logic [DW-1:0]  oStoreData,
  output logic           oValid,
  output logic           oRegWrite,
  output logic           oMemRead,
  output logic           oMemWrite,
  output logic [4:0]     oWriteAddr,
  output logic [31:0]    oPC,
  output logic           oLoadUse,
  output logic [CW-1:0]  oBubbleCount
);

  typedef struct packed {
    logic           valid;
    logic [31:0]    pc;
    logic [DW-1:0]  rsData;
    logic [DW-1:0]  rtData;
    logic [DW-1:0]  imm;
    logic [4:0]     shamt;
    logic [OPW-1:0] aluOp;
    logic           srcBImm;
    logic [4:0]     rsAddr;
    logic [4:0]     rtAddr;
    logic           useRs;
    logic           useRt;
    logic [4:0]     writeAddr;
    logic           regWrite;
    logic           memRead;
    logic           memWrite;
  } stage_t;

  stage_t        rStage;
  stage_t        dStage;
  logic [CW-1:0] rBubbleCount;
  logic          loadUse;
  logic          insertBubble;
  logic [DW-1:0] fwdRs;
  logic [DW-1:0] fwdRt;
  logic          unusedUseBits;

  always_comb begin
    dStage           = '0;
    dStage.valid     = iValid;
    dStage.pc        = iPC;
    dStage.rsData    = iRsData;
    dStage.rtData    = iRtData;
    dStage.imm       = iImm;
    dStage.shamt     = iShamt;
    dStage.aluOp     = iALUOp;
    dStage.srcBImm   = iSrcBImm;
    dStage.rsAddr    = iRsAddr;
    dStage.rtAddr    = iRtAddr;
    dStage.useRs     = iUseRs;
    dStage.useRt     = iUseRt;
    dStage.writeAddr = iWriteAddr;
    dStage.regWrite  = iRegWrite;
    dStage.memRead   = iMemRead;
    dStage.memWrite  = iMemWrite;
  end

  // A load in this stage cannot feed the instruction behind it; that one must wait a cycle.
  assign loadUse = rStage.valid & rStage.memRead & (rStage.writeAddr != 5'd0) & iValid &
                   ((iUseRs & (iRsAddr == rStage.writeAddr)) |
                    (iUseRt & (iRtAddr == rStage.writeAddr)));

  assign insertBubble = ~iStall & (iFlush | loadUse);

  // A bubble is the all-zero stage image, which also reads as ALU op add.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rStage <= '0;
    end else if (!iStall) begin
      rStage <= insertBubble ? '0 : dStage;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rBubbleCount <= '0;
    end else if (insertBubble && (rBubbleCount != '1)) begin
      rBubbleCount <= rBubbleCount + CW'(1);
    end
  end

  // MEM is the younger result, so it wins over WB; register 0 is hardwired and never forwarded.
  always_comb begin
    fwdRs = rStage.rsData;
    if (iFwdMemWe && (iFwdMemAddr != 5'd0) && (iFwdMemAddr == rStage.rsAddr)) begin
      fwdRs = iFwdMemData;
    end else if (iFwdWbWe && (iFwdWbAddr != 5'd0) && (iFwdWbAddr == rStage.rsAddr)) begin
      fwdRs = iFwdWbData;
    end
  end

  always_comb begin
    fwdRt = rStage.rtData;
    if (iFwdMemWe && (iFwdMemAddr != 5'd0) && (iFwdMemAddr == rStage.rtAddr)) begin
      fwdRt = iFwdMemData;
    end else if (iFwdWbWe && (iFwdWbAddr != 5'd0) && (iFwdWbAddr == rStage.rtAddr)) begin
      fwdRt = iFwdWbData;
    end
  end

  // The use bits are kept with the instruction but nothing in EX consumes them yet.
  assign unusedUseBits = rStage.useRs ^ rStage.useRt;

  assign oNumber1     = fwdRs;
  assign oNumber2     = rStage.srcBImm ? rStage.imm : fwdRt;
  assign oStoreData   = fwdRt;
  assign oShamt       = rStage.shamt;
  assign oALUOp       = rStage.aluOp;
  assign oValid       = rStage.valid;
  assign oRegWrite    = rStage.regWrite;
  assign oMemRead     = rStage.memRead;
  assign oMemWrite    = rStage.memWrite;
  assign oWriteAddr   = rStage.writeAddr;
  assign oPC          = rStage.pc;
  assign oLoadUse     = loadUse;
  assign oBubbleCount = rBubbleCount;

endmodule
